dense_layer_mac: RTL and testbench

Parametrised fully-connected layer engine for the MNIST inference datapath. Acting as an Avalon-MM master on the SDRAM port, it computes N_OUT signed fixed-point dot products of length N_IN over an input vector and a row-major weight matrix. It rescales and saturates each result and writes it back to memory. It is started and completed through the same `ready`/`done` handshake used by the other layer blocks, so layers can be chained by the top-level controller.

---
 rtl/dense_layer_mac_if.sv | 41 ++++
 rtl/dense_layer_mac.sv | 187 ++++++++++++++++++
 tb/tb_dense_layer_mac.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_mac_if
// Purpose  : Bundles the Avalon-MM master bus of the dense layer engine with
//            its ready/done layer handshake and debug display word.
// Ports    : waitrequest, readdatavalid, readdata  slave -> engine
//            chipselect, byteenable, read_n, write_n,
//            address, writedata                    engine -> slave
//            ready                                 controller -> engine
//            done, toHexLed                        engine -> controller
// Revision : 1.0  initial release
// ============================================================================
interface dense_layer_mac_if #(
  parameter int DATA_W = 16
);
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;
  logic              chipselect;
  logic [1:0]        byteenable;
  logic              read_n;
  logic              write_n;
  logic [31:0]       address;
  logic [DATA_W-1:0] writedata;
  logic              ready;
  logic              done;
  logic [31:0]       toHexLed;

  modport master (
    input  waitrequest, readdatavalid, readdata, ready,
    output chipselect, byteenable, read_n, write_n, address, writedata,
           done, toHexLed
  );

  modport slave (
    output waitrequest, readdatavalid, readdata, ready,
    input  chipselect, byteenable, read_n, write_n, address, writedata,
           done, toHexLed
  );
endinterface
`default_nettype wire

// File: rtl/dense_layer_mac.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_mac
// Purpose  : Fully-connected layer engine. Reads x[i] and w[j][i] one element
//            at a time over Avalon-MM, accumulates N_IN signed products per
//            neuron, rescales by FRAC (floor), saturates to DATA_W and writes
//            y[j]. Started by a level 'ready', completion flagged by 'done'.
// Ports    : clk      system clock (rising edge)
//            reset_n  asynchronous active-low reset
//            bus      dense_layer_mac_if.master (Avalon bus + ready/done/hex)
// Options  : RELU_EN  when defined, negative saturated results are written as 0
// Revision : 1.0  initial release
// ============================================================================
module dense_layer_mac #(
  parameter int          DATA_W   = 16,
  parameter int          N_IN     = 784,
  parameter int          N_OUT    = 200,
  parameter int          FRAC     = 8,
  parameter logic [31:0] IN_BASE  = 32'd400_000,
  parameter logic [31:0] W_BASE   = 32'd800,
  parameter logic [31:0] OUT_BASE = 32'd650_000
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  dense_layer_mac_if.master  bus
);

  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ACC_W = 2*DATA_W + $clog2(N_IN);

  // Saturation bounds expressed at accumulator width so the compare is signed.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_X   = 3'd1,
    S_WAIT_X = 3'd2,
    S_RD_W   = 3'd3,
    S_WAIT_W = 3'd4,
    S_MAC    = 3'd5,
    S_WR     = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d;
  logic [JW-1:0]             j_q, j_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  x_q, x_d;
  logic signed [DATA_W-1:0]  w_q, w_d;
  logic [7:0]                lastrd_q, lastrd_d;
  logic                      read_n_q, read_n_d;
  logic                      write_n_q, write_n_d;
  logic [31:0]               address_q, address_d;
  logic [DATA_W-1:0]         writedata_q, writedata_d;
  logic                      done_q, done_d;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = x_q * w_q;

  // Floor shift, clamp to DATA_W, optional rectification.
  function automatic logic [DATA_W-1:0] scale_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    logic [DATA_W-1:0]       r;
    sh = a >>> FRAC;
    if (sh > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
    else if (sh < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
    else                   r = sh[DATA_W-1:0];
`ifdef RELU_EN
    if (r[DATA_W-1]) r = '0;
`endif
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    x_d         = x_q;
    w_d         = w_q;
    lastrd_d    = lastrd_q;
    writedata_d = writedata_q;
    address_d   = address_q;

    case (state_q)
      S_IDLE: begin
        i_d   = '0;
        j_d   = '0;
        acc_d = '0;
        if (bus.ready) state_d = S_RD_X;
      end
      S_RD_X:   if (!bus.waitrequest) state_d = S_WAIT_X;
      S_WAIT_X: if (bus.readdatavalid) begin
        x_d      = bus.readdata;
        lastrd_d = bus.readdata[7:0];
        state_d  = S_RD_W;
      end
      S_RD_W:   if (!bus.waitrequest) state_d = S_WAIT_W;
      S_WAIT_W: if (bus.readdatavalid) begin
        w_d      = bus.readdata;
        lastrd_d = bus.readdata[7:0];
        state_d  = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (i_q != IW'(N_IN-1)) begin
          i_d     = i_q + 1'b1;
          state_d = S_RD_X;
        end else begin
          // WR is only ever entered from here, so the result is latched once.
          writedata_d = scale_out(acc_d);
          state_d     = S_WR;
        end
      end
      S_WR: if (!bus.waitrequest) begin
        acc_d = '0;
        i_d   = '0;
        if (j_q != JW'(N_OUT-1)) begin
          j_d     = j_q + 1'b1;
          state_d = S_RD_X;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  if (!bus.ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes/address are registered from the next state so they are valid
    // in the very first cycle of RD_*/WR and drop right after acceptance.
    read_n_d  = !((state_d == S_RD_X) || (state_d == S_RD_W));
    write_n_d = (state_d != S_WR);
    done_d    = (state_d == S_DONE);
    case (state_d)
      S_RD_X:  address_d = IN_BASE + (32'(i_d) << 1);
      S_RD_W:  address_d = W_BASE + ((32'(j_d) * 32'(N_IN) + 32'(i_d)) << 1);
      S_WR:    address_d = OUT_BASE + (32'(j_d) << 1);
      default: address_d = address_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      w_q         <= '0;
      lastrd_q    <= '0;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
      address_q   <= '0;
      writedata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      w_q         <= w_d;
      lastrd_q    <= lastrd_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      done_q      <= done_d;
    end
  end

  assign bus.chipselect = 1'b1;
  assign bus.byteenable = 2'b11;
  assign bus.read_n     = read_n_q;
  assign bus.write_n    = write_n_q;
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign bus.done       = done_q;
  assign bus.toHexLed   = {16'(j_q), lastrd_q, 8'(state_q)};

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_layer_mac
// Purpose  : Self-checking bench. Two engines (FRAC=0 and FRAC=8, N_IN=4,
//            N_OUT=2) each talk to a memory slave model with programmable
//            wait states; results are compared against a dot-product model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dense_layer_mac;
  localparam int          N_IN  = 4;
  localparam int          N_OUT = 2;
  localparam int          NR    = 2 * N_IN * N_OUT;
  localparam logic [31:0] IN_B  = 32'd400_000;
  localparam logic [31:0] W_B   = 32'd800;
  localparam logic [31:0] O_B   = 32'd650_000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dense_layer_mac_if #(.DATA_W(16)) bus0 ();
  dense_layer_mac_if #(.DATA_W(16)) bus1 ();

  dense_layer_mac #(.DATA_W(16), .N_IN(N_IN), .N_OUT(N_OUT), .FRAC(0),
    .IN_BASE(IN_B), .W_BASE(W_B), .OUT_BASE(O_B))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.master));

  dense_layer_mac #(.DATA_W(16), .N_IN(N_IN), .N_OUT(N_OUT), .FRAC(8),
    .IN_BASE(IN_B), .W_BASE(W_B), .OUT_BASE(O_B))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.master));

  // ---------------- slave memory model (one per engine) ----------------
  logic [1:0]  rdy, wreq, rn, wn, dn;
  logic [1:0]  rdv = 2'b00;
  logic [15:0] rdata [2] = '{16'h0, 16'h0};
  logic [31:0] addr  [2];
  logic [15:0] wd    [2];
  int          ws    [2] = '{0, 0};
  int          cnt   [2] = '{0, 0};
  logic [15:0] xm    [2][N_IN];
  logic [15:0] wm    [2][N_IN*N_OUT];

  int          cyc = 0;
  int          rd_cnt [2] = '{0, 0};
  int          wr_cnt [2] = '{0, 0};
  int          wr_cyc [2] = '{0, 0};
  int          stall_viol [2] = '{0, 0};
  int          both_viol  [2] = '{0, 0};
  logic [31:0] rd_log [2][1024];
  logic [31:0] wr_alog[2][1024];
  logic [15:0] wr_dlog[2][1024];
  logic        hold_v [2] = '{1'b0, 1'b0};
  logic [31:0] hold_a [2];
  logic [1:0]  hold_s [2];

  assign bus0.ready = rdy[0];  assign bus1.ready = rdy[1];
  assign bus0.waitrequest = wreq[0];  assign bus1.waitrequest = wreq[1];
  assign bus0.readdatavalid = rdv[0]; assign bus1.readdatavalid = rdv[1];
  assign bus0.readdata = rdata[0];    assign bus1.readdata = rdata[1];
  assign rn[0] = bus0.read_n;   assign rn[1] = bus1.read_n;
  assign wn[0] = bus0.write_n;  assign wn[1] = bus1.write_n;
  assign dn[0] = bus0.done;     assign dn[1] = bus1.done;
  assign addr[0] = bus0.address;   assign addr[1] = bus1.address;
  assign wd[0] = bus0.writedata;   assign wd[1] = bus1.writedata;
  assign wreq[0] = (!rn[0] || !wn[0]) && (cnt[0] < ws[0]);
  assign wreq[1] = (!rn[1] || !wn[1]) && (cnt[1] < ws[1]);

  function automatic logic [15:0] mem_rd(input int k, input logic [31:0] a);
    if (a >= IN_B && a < IN_B + 2*N_IN) return xm[k][(a - IN_B) / 2];
    if (a >= W_B && a < W_B + 2*N_IN*N_OUT) return wm[k][(a - W_B) / 2];
    return 16'hDEAD;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      rdv[k]    <= 1'b0;
      hold_v[k] <= 1'b0;
      if (hold_v[k] && reset_n && (addr[k] != hold_a[k] || {rn[k], wn[k]} != hold_s[k]))
        stall_viol[k] <= stall_viol[k] + 1;
      if (!rn[k] && !wn[k]) both_viol[k] <= both_viol[k] + 1;
      if (!rn[k] || !wn[k]) begin
        if (wreq[k]) begin
          cnt[k]    <= cnt[k] + 1;
          hold_v[k] <= 1'b1;
          hold_a[k] <= addr[k];
          hold_s[k] <= {rn[k], wn[k]};
        end else begin
          cnt[k] <= 0;
          if (!rn[k]) begin
            rd_log[k][rd_cnt[k] % 1024] <= addr[k];
            rd_cnt[k] <= rd_cnt[k] + 1;
            rdv[k]    <= 1'b1;
            rdata[k]  <= mem_rd(k, addr[k]);
          end else begin
            wr_alog[k][wr_cnt[k] % 1024] <= addr[k];
            wr_dlog[k][wr_cnt[k] % 1024] <= wd[k];
            wr_cnt[k] <= wr_cnt[k] + 1;
            wr_cyc[k] <= cyc;
          end
        end
      end else begin
        cnt[k] <= 0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer dot product, floor divide by 2^FRAC, clamp, optional ReLU.
  function automatic logic [15:0] model_y(input int k, input int j);
    longint s;
    int     frac;
    frac = (k == 0) ? 0 : 8;
    s = 0;
    for (int i = 0; i < N_IN; i++)
      s += longint'($signed(xm[k][i])) * longint'($signed(wm[k][j*N_IN + i]));
    s = s >>> frac;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return s[15:0];
  endfunction

  task automatic load(input int k, input int x0, input int x1, input int x2, input int x3,
                      input int wa, input int wb);
    xm[k][0] = 16'(x0); xm[k][1] = 16'(x1); xm[k][2] = 16'(x2); xm[k][3] = 16'(x3);
    for (int i = 0; i < N_IN; i++) begin
      wm[k][i]        = (i == 0) ? 16'(wa) : ((k == 1 && i == 1) ? 16'(wb) : 16'(0));
      wm[k][N_IN + i] = 16'(0);
    end
  endtask

  task automatic run_layer(input int k, input int wsv, input bit pulse, input string tag);
    int  r0, w0, jj, ii;
    bit  seen;
    logic [31:0] ea;
    ws[k] = wsv;
    r0 = rd_cnt[k];
    w0 = wr_cnt[k];
    rdy[k] = 1'b1;
    if (pulse) begin
      @(negedge clk);
      rdy[k] = 1'b0;
    end
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (dn[k]) seen = 1'b1;
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_val({tag, "_done_lat"}, 32'(cyc - wr_cyc[k]), 32'd1);
      if (!pulse) begin
        repeat (3) @(negedge clk);
        check_val({tag, "_done_hold"}, 32'(dn[k]), 32'd1);
        rdy[k] = 1'b0;
      end
      @(negedge clk);
      check_val({tag, "_done_fall"}, 32'(dn[k]), 32'd0);
      @(negedge clk);
      check_val({tag, "_idle_strobes"}, 32'({rn[k], wn[k]}), 32'd3);
    end
    rdy[k] = 1'b0;
    check_val({tag, "_nreads"}, 32'(rd_cnt[k] - r0), 32'(NR));
    check_val({tag, "_nwrites"}, 32'(wr_cnt[k] - w0), 32'(N_OUT));
    for (int n = 0; n < NR; n++) begin
      jj = n / (2*N_IN);
      ii = (n % (2*N_IN)) / 2;
      ea = (n % 2 == 0) ? IN_B + 32'(2*ii) : W_B + 32'(2*(jj*N_IN + ii));
      check_val($sformatf("%s_rdaddr%0d", tag, n), rd_log[k][(r0 + n) % 1024], ea);
    end
    for (int j = 0; j < N_OUT; j++) begin
      check_val($sformatf("%s_wraddr%0d", tag, j), wr_alog[k][(w0 + j) % 1024], O_B + 32'(2*j));
      check_val($sformatf("%s_y%0d", tag, j), 32'(wr_dlog[k][(w0 + j) % 1024]), 32'(model_y(k, j)));
    end
  endtask

  task automatic load_basic(input int k);
    xm[k][0] = 16'd1; xm[k][1] = 16'd2; xm[k][2] = 16'd3; xm[k][3] = 16'd4;
    for (int i = 0; i < N_IN; i++) begin
      wm[k][i]        = 16'd1;
      wm[k][N_IN + i] = (i == 0) ? 16'hFFFF : 16'd0;
    end
  endtask

  task automatic load_const(input int k, input logic [15:0] xv, input logic [15:0] wv);
    for (int i = 0; i < N_IN; i++) xm[k][i] = xv;
    for (int i = 0; i < N_IN*N_OUT; i++) wm[k][i] = wv;
  endtask

  initial begin
    bit reached;
    int r0;
    reset_n = 1'b1;
    rdy     = 2'b00;
    load_const(0, 16'd0, 16'd0);
    load_const(1, 16'd0, 16'd0);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_read_n",    32'(bus0.read_n),     32'd1);
    check_val("rst_write_n",   32'(bus0.write_n),    32'd1);
    check_val("rst_address",   bus0.address,         32'd0);
    check_val("rst_writedata", 32'(bus0.writedata),  32'd0);
    check_val("rst_done",      32'(bus0.done),       32'd0);
    check_val("chipselect",    32'(bus0.chipselect), 32'd1);
    check_val("byteenable",    32'(bus0.byteenable), 32'd3);
    check_val("rst_hex_state", 32'(bus0.toHexLed[7:0]), 32'd0);
    check_val("rst1_strobes",  32'({bus1.read_n, bus1.write_n}), 32'd3);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_no_start", 32'({rn[0], wn[0]}), 32'd3);

    // Hand-written result expectations for the basic vector.
    load_basic(0);
    run_layer(0, 0, 1'b0, "basic");
`ifdef RELU_EN
    check_val("basic_y1_abs", 32'(wr_dlog[0][(wr_cnt[0] - 1) % 1024]), 32'h0000);
`else
    check_val("basic_y1_abs", 32'(wr_dlog[0][(wr_cnt[0] - 1) % 1024]), 32'hFFFF);
`endif
    check_val("basic_y0_abs", 32'(wr_dlog[0][(wr_cnt[0] - 2) % 1024]), 32'd10);

    load_const(0, 16'h7FFF, 16'h7FFF);
    run_layer(0, 0, 1'b0, "sat_pos");
    load_const(0, 16'h7FFF, 16'h8000);
    run_layer(0, 0, 1'b0, "sat_neg");

    load_basic(0);
    run_layer(0, 3, 1'b0, "stall");
    run_layer(0, 0, 1'b1, "pulse");
    run_layer(0, 0, 1'b0, "rerun");

    // Reset while waiting for weight data of neuron 0.
    ws[0] = 0;
    r0 = rd_cnt[0];
    rdy[0] = 1'b1;
    reached = 1'b0;
    for (int t = 0; t < 200 && !reached; t++) begin
      @(negedge clk);
      if (rd_cnt[0] == r0 + 2) reached = 1'b1;
    end
    check_val("rst_ww_reached", 32'(reached), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("rst_ww_strobes", 32'({rn[0], wn[0]}), 32'd3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_layer(0, 0, 1'b0, "after_rst1");

    // Reset while a read strobe is being stalled: strobe must drop immediately.
    ws[0] = 3;
    r0 = rd_cnt[0];
    rdy[0] = 1'b1;
    reached = 1'b0;
    for (int t = 0; t < 200 && !reached; t++) begin
      @(negedge clk);
      if (rd_cnt[0] == r0 + 1 && !rn[0]) reached = 1'b1;
    end
    check_val("rst_rd_reached", 32'(reached), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("rst_rd_read_n", 32'(rn[0]), 32'd1);
    check_val("rst_rd_addr",   addr[0],    32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_layer(0, 3, 1'b0, "after_rst2");

    // FRAC=8 rounding: -1 -> -1, 255 -> 0, then 256 -> 1 for both neurons.
    load(1, 1, 1, 1, 1, 0, 0);
    wm[1][0] = 16'hFFFF;
    wm[1][N_IN] = 16'd255;
    run_layer(1, 0, 1'b0, "round_a");
    wm[1][0] = 16'd256;
    wm[1][N_IN] = 16'd128;
    wm[1][N_IN + 1] = 16'd128;
    run_layer(1, 1, 1'b0, "round_b");

    for (int r = 0; r < 6; r++) begin
      int k;
      k = r % 2;
      for (int i = 0; i < N_IN; i++) xm[k][i] = 16'($urandom);
      for (int i = 0; i < N_IN*N_OUT; i++) wm[k][i] = 16'($urandom);
      run_layer(k, int'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", r));
    end

    check_val("stall_stable0", 32'(stall_viol[0]), 32'd0);
    check_val("stall_stable1", 32'(stall_viol[1]), 32'd0);
    check_val("rd_wr_excl0",   32'(both_viol[0]),  32'd0);
    check_val("rd_wr_excl1",   32'(both_viol[1]),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
